// File: rtl/clken_seq.sv
// clken_seq: PLL-lock-qualified reset sequencer plus CHANNELS programmable
// clock-enable strobes. Divide values take effect only at each channel's
// period boundary, so ratio changes never produce a runt enable.
module clken_seq #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned DEFAULT_DIV   = 1,
  localparam int unsigned SelW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                pll_locked,
  input  logic                div_wr,
  input  logic [SelW-1:0]     div_sel,
  input  logic [DIV_W-1:0]    div_val,
  output logic [CHANNELS-1:0] ce,
  output logic                sys_reset_n,
  output logic                running
);

  localparam int unsigned StabW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DivReset = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    StWaitLock,
    StStable,
    StRun
  } state_e;

  // Lock synchroniser
  logic s1_q;
  logic lock_s_q;

  // Sequencer state
  state_e           state_q, state_d;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic             running_q;
  logic             sys_reset_n_q;

  // Per-channel divider state
  logic [DIV_W-1:0]    cnt_q     [CHANNELS];
  logic [DIV_W-1:0]    cnt_d     [CHANNELS];
  logic [DIV_W-1:0]    div_reg_q [CHANNELS];
  logic [DIV_W-1:0]    div_reg_d [CHANNELS];
  logic [DIV_W-1:0]    pend_q    [CHANNELS];
  logic [DIV_W-1:0]    pend_d    [CHANNELS];
  logic [CHANNELS-1:0] pend_valid_q, pend_valid_d;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] wr_hit;

  // Channels count only while the sequencer is in RUN and stays there on this
  // edge; the entry edge and the abort edge both leave counters cleared.
  logic run_act;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q     <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      s1_q     <= pll_locked;
      lock_s_q <= s1_q;
    end
  end

  // Sequencer next-state: wait for lock, require it stable, then run
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s_q) begin
          state_d    = StStable;
          stab_cnt_d = '0;
        end
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
        end else if (stab_cnt_q == StabLast) begin
          state_d = StRun;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
        end
      end
      default: begin
        state_d = StWaitLock;
      end
    endcase
  end

  // Sequencer state and registered run/reset outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= StWaitLock;
      stab_cnt_q    <= '0;
      running_q     <= 1'b0;
      sys_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      running_q     <= (state_d == StRun);
      sys_reset_n_q <= (state_d == StRun);
    end
  end

  assign run_act = (state_q == StRun) && (state_d == StRun);

  // Decode the write target; out-of-range selects match no channel
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = div_wr && (div_sel == SelW'(i));
    end
  end

  // Channel next-state: count, strobe at terminal, load pending at load points
  always_comb begin
    cnt_d        = cnt_q;
    div_reg_d    = div_reg_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ce_d         = '0;
    load         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!run_act) begin
        // Idle: discard the in-flight period, pending value loads at once
        cnt_d[i] = '0;
        load[i]  = pend_valid_q[i];
      end else if (div_reg_q[i] == '0) begin
        cnt_d[i] = '0;
        load[i]  = pend_valid_q[i];
      end else if (cnt_q[i] == (div_reg_q[i] - 1'b1)) begin
        cnt_d[i] = '0;
        ce_d[i]  = 1'b1;
        load[i]  = pend_valid_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (load[i]) begin
        div_reg_d[i]    = pend_q[i];
        pend_valid_d[i] = 1'b0;
      end

      // A write coinciding with a load wins the pending slot; the load above
      // already consumed the old value.
      if (wr_hit[i]) begin
        pend_d[i]       = div_val;
        pend_valid_d[i] = 1'b1;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        div_reg_q[i] <= DivReset;
        pend_q[i]    <= '0;
      end
      pend_valid_q <= '0;
      ce_q         <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_reg_q[i] <= div_reg_d[i];
        pend_q[i]    <= pend_d[i];
      end
      pend_valid_q <= pend_valid_d;
      ce_q         <= ce_d;
    end
  end

  assign ce          = ce_q;
  assign running     = running_q;
  assign sys_reset_n = sys_reset_n_q;

endmodule

// File: doc/clken_seq.md
# clken_seq

Parametrised clock-enable generator and reset sequencer for the emulator core. It runs on a single PLL output clock and waits for the PLL lock to be stable before releasing a system reset. It then produces CHANNELS independent one-cycle clock-enable strobes (CPU, video, sound, tape, and so on) at run-time programmable divide ratios. New ratios are applied glitch-free at each channel's period boundary, so CPU speed modes can change without runt enables.

## Interface
Parameters:
- CHANNELS, 4, number of clock-enable outputs (≥1)
- DIV_W, 16, width of each divide value
- STABLE_CYCLES, 256, cycles pll_locked must stay high before run (≥1)
- DEFAULT_DIV, 1, divide value loaded into every channel at reset

Ports:
- clk_clk  in  1  sole clock
- reset_reset_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock, asynchronous; synchronised internally by 2 flops
- div_wr  in  1  write strobe for a new divide value
- div_sel  in  max(1,$clog2(CHANNELS))  target channel
- div_val  in  DIV_W  new divide value; 0 = channel disabled
- ce  out  CHANNELS  per-channel clock-enable strobes
- sys_reset_n  out  1  registered active-low system reset for downstream logic
- running  out  1  high while in RUN

## Operation
- Reset values: ce=0, sys_reset_n=0, running=0, sync flops=0, state=WAIT_LOCK, all counters=0, div_reg[i]=DEFAULT_DIV, pend_valid=0.
- Lock synchroniser: pll_locked → s1 → lock_s.
- FSM:
  - WAIT_LOCK: when lock_s=1, go to STABLE and clear stab_cnt.
  - STABLE: if lock_s=0, return to WAIT_LOCK. Otherwise stab_cnt+1; when stab_cnt==STABLE_CYCLES-1, go to RUN.
  - RUN: if lock_s=0, return to WAIT_LOCK.
- sys_reset_n and running are registered. Both are 1 exactly when the state is RUN, and update on the same edge as the state.
- Outside RUN: all ce=0 and all cnt[i]=0.
- Divide writes are accepted in any state. When div_wr=1 and div_sel<CHANNELS: pend[sel]<=div_val and pend_valid[sel]<=1. If div_sel≥CHANNELS, the write is ignored.
- Loading pending values:
  - Outside RUN, a pending value loads into div_reg on the next edge and pend_valid clears.
  - In RUN, a pending value loads only at a load point: the terminal edge (cnt==div_reg-1), or any edge while div_reg==0. On load, cnt<=0.
- Write and load on the same edge: the load takes the old pend value. The new write lands in pend and pend_valid stays 1, so the new value loads at the next load point.
- Channel behaviour in RUN:
  - div_reg==0: cnt=0, ce=0.
  - Terminal: cnt<=0, ce<=1.
  - Otherwise: cnt+1, ce<=0.
  - Result: one-cycle ce every div_reg cycles; ce held high continuously for div_reg=1.
- Arithmetic: compares are on DIV_W bits; cnt never exceeds div_reg-1. div_reg=2^DIV_W-1 is legal.
- Lock loss mid-run aborts immediately. All in-flight periods are discarded; div_reg and pend are retained.
- Asynchronous reset at any time restores the reset values on the next evaluation, with no clock required.

## Timing
- Lock rise: number edges from the first edge that samples pll_locked=1 (edge 1).
  - lock_s=1 after edge 2.
  - STABLE entered at edge 3.
  - running=1 and sys_reset_n=1 after edge STABLE_CYCLES+3, provided lock stays high throughout.
- Lock fall (edge 1 samples 0): running=0, sys_reset_n=0 and ce=0 after edge 3.
- A lock glitch shorter than 1 cycle may be missed. Any lock_s low during STABLE restarts the full stable count.
- First ce after RUN entry: high N cycles after running rises (N=div_reg).
- Divide change in RUN: the current period completes at the old N. The period after the terminal edge uses the new N. Worst-case latency from write to applied is old N cycles.
- Enabling a disabled channel (0→N): loads 1 edge after the write. The first ce follows N cycles later.

## Test plan
- Lock sequence: STABLE_CYCLES=8, raise pll_locked before edge 1 → running and sys_reset_n rise after edge 11, with ce all 0 before that.
- Lock glitch: drop pll_locked for 3 cycles at stab_cnt=5 → returns to WAIT_LOCK and the count restarts; running rises 11 edges after lock is sampled high again.
- Divide ratios: CHANNELS=4, div 1/2/3/0 → ce[0] constant 1, ce[1] period 2, ce[2] period 3, ce[3] never asserts. Check each period against a reference counter over 1000 cycles.
- Glitch-free change: channel at N=5, write 2 mid-period (cnt=1) → next ce 3 cycles later at the old ratio, then period 2. No pulse gap shorter than 2 cycles.
- Write collision: write 7 then 4 on consecutive cycles, with the second on the terminal edge → 7 is loaded for exactly one period, then 4 applies. Also write div_sel=4 with CHANNELS=4 → no channel changes.
- Lock loss and reset: drop pll_locked in RUN → ce=0 and sys_reset_n=0 after 3 edges, div_reg retained; on relock the same ratios resume. Assert reset_reset_n asynchronously mid-cycle → all outputs 0 immediately and div_reg=DEFAULT_DIV.
